// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Optional forwarding build is selected with the HAZARD_FWD_EN macro.
package hazard_pkg;

    // Register address width carried in the shadow entries
    localparam int REG_AW = 5;

    // Registered action of the controller, visible on hz_state
    typedef enum logic [1:0] {
        HZ_RUN      = 2'b00,
        HZ_LU_STALL = 2'b01,
        HZ_JR_STALL = 2'b10,
        HZ_FLUSH    = 2'b11
    } hz_state_t;

    // EX operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // One in-flight instruction as seen by the hazard logic
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic              regwrite;
        logic [REG_AW-1:0] rw;
        logic              memread;
    } shadow_t;

    // An entry only produces a register value when it is live, writes,
    // and does not target $zero
    function automatic logic writes_reg(input shadow_t e);
        return e.valid & e.regwrite & (e.rw != '0);
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_unit.sv
// Forwarding select for a single EX operand.
// MEM/WB producers are compared against the operand's source register;
// the youngest producer (MEM) wins, and $zero is never forwarded.
module fwd_unit
    import hazard_pkg::*;
#(
    parameter int RA_W = 5
) (
    input  logic [RA_W-1:0] src,
    input  logic            mem_wr,
    input  logic [RA_W-1:0] mem_rw,
    input  logic            wb_wr,
    input  logic [RA_W-1:0] wb_rw,
    output logic [1:0]      sel
);

    // Pick the most recent in-flight producer of src
    always_comb begin
        sel = FWD_REG;
        if (src != '0) begin
            if (mem_wr && (mem_rw == src)) begin
                sel = FWD_MEM;
            end else if (wb_wr && (wb_rw == src)) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage datapath.
// Tracks EX/MEM/WB destination registers in a shadow pipeline and
// produces stall, flush and forwarding controls plus debug counters.
// Build option: define HAZARD_FWD_EN to enable EX-stage forwarding;
// without it, every RAW dependency on EX or MEM is resolved by stalling.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int RA_W  = 5
) (
    input  logic             slow_clk,
    input  logic             Reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs,
    input  logic [RA_W-1:0]  id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_regwrite,
    input  logic [RA_W-1:0]  id_rw,
    input  logic             id_memread,
    input  logic             id_jump,
    input  logic             id_jr,
    input  logic             ex_branch_taken,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    shadow_t    ex_reg, mem_reg, wb_reg;
    shadow_t    ex_next;
    hz_state_t  hz_state_reg, action_next;
    logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

    logic pc_stall_next, ifid_stall_next, ifid_flush_next, idex_flush_next;
    logic rs_used, rt_used;
    logic ex_wr, mem_wr;
    logic ex_src_hit;
    logic load_use, jr_hz;
    logic stall_event, flush_event;

    assign rs_used = id_valid & id_use_rs;
    assign rt_used = id_valid & id_use_rt;
    assign ex_wr   = writes_reg(ex_reg);
    assign mem_wr  = writes_reg(mem_reg);

    // Does the ID instruction read the register produced in EX?
    assign ex_src_hit = (rs_used && (id_rs == ex_reg.rw)) ||
                        (rt_used && (id_rt == ex_reg.rw));

`ifdef HAZARD_FWD_EN
    // With forwarding, only a load in EX cannot be bypassed in time
    assign load_use = ex_wr & ex_reg.memread & ex_src_hit;
`else
    logic mem_src_hit;
    assign mem_src_hit = (rs_used && (id_rs == mem_reg.rw)) ||
                         (rt_used && (id_rt == mem_reg.rw));
    // Without forwarding, any producer still in EX or MEM must drain;
    // WB is fine because the regfile writes before ID reads
    assign load_use = (ex_wr & ex_src_hit) | (mem_wr & mem_src_hit);
`endif

    // JR reads rs in ID, where nothing is forwarded
    assign jr_hz = id_jr & id_valid &
                   ((ex_wr  && (ex_reg.rw  == id_rs)) ||
                    (mem_wr && (mem_reg.rw == id_rs)));

    // Prioritised selection of this cycle's action and its controls
    always_comb begin
        action_next     = HZ_RUN;
        pc_stall_next   = 1'b0;
        ifid_stall_next = 1'b0;
        ifid_flush_next = 1'b0;
        idex_flush_next = 1'b0;
        if (ex_branch_taken) begin
            ifid_flush_next = 1'b1;
            idex_flush_next = 1'b1;
            action_next     = HZ_FLUSH;
        end else if (load_use) begin
            pc_stall_next   = 1'b1;
            ifid_stall_next = 1'b1;
            idex_flush_next = 1'b1;
            action_next     = HZ_LU_STALL;
        end else if (jr_hz) begin
            pc_stall_next   = 1'b1;
            ifid_stall_next = 1'b1;
            idex_flush_next = 1'b1;
            action_next     = HZ_JR_STALL;
        end else if (id_valid && (id_jump || id_jr)) begin
            ifid_flush_next = 1'b1;
            action_next     = HZ_FLUSH;
        end
    end

    // Entry that moves into the EX shadow; a bubble when ID/EX is flushed
    always_comb begin
        ex_next = '0;
        if (!idex_flush_next) begin
            ex_next.valid    = id_valid;
            ex_next.rs       = id_rs;
            ex_next.rt       = id_rt;
            ex_next.regwrite = id_regwrite;
            ex_next.rw       = id_rw;
            ex_next.memread  = id_memread;
        end
    end

    // Shadow pipeline advances every cycle alongside the datapath
    always_ff @(posedge slow_clk or posedge Reset) begin
        if (Reset) begin
            ex_reg  <= '0;
            mem_reg <= '0;
            wb_reg  <= '0;
        end else begin
            wb_reg  <= mem_reg;
            mem_reg <= ex_reg;
            ex_reg  <= ex_next;
        end
    end

    assign stall_event = (action_next == HZ_LU_STALL) || (action_next == HZ_JR_STALL);
    assign flush_event = (action_next == HZ_FLUSH);

    // Action register plus saturating debug counters
    always_ff @(posedge slow_clk or posedge Reset) begin
        if (Reset) begin
            hz_state_reg  <= HZ_RUN;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            hz_state_reg <= action_next;
            if (stall_event && (stall_cnt_reg != {CNT_W{1'b1}})) begin
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            end
            if (flush_event && (flush_cnt_reg != {CNT_W{1'b1}})) begin
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
            end
        end
    end

`ifdef HAZARD_FWD_EN
    logic            wb_wr;
    logic [RA_W-1:0] op_src [2];
    logic [1:0]      op_sel [2];

    assign wb_wr     = writes_reg(wb_reg);
    assign op_src[0] = ex_reg.rs;
    assign op_src[1] = ex_reg.rt;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            fwd_unit #(.RA_W(RA_W)) u_fwd (
                .src    (op_src[gi]),
                .mem_wr (mem_wr),
                .mem_rw (mem_reg.rw),
                .wb_wr  (wb_wr),
                .wb_rw  (wb_reg.rw),
                .sel    (op_sel[gi])
            );
        end
    endgenerate

    assign fwd_a = op_sel[0];
    assign fwd_b = op_sel[1];
`else
    assign fwd_a = FWD_REG;
    assign fwd_b = FWD_REG;
`endif

    // Not every shadow field is consumed in every build
    logic unused_shadow;
    assign unused_shadow = ^{ex_reg, mem_reg, wb_reg};

    // Control outputs drop together with the asynchronous reset
    assign pc_stall   = pc_stall_next   & ~Reset;
    assign ifid_stall = ifid_stall_next & ~Reset;
    assign ifid_flush = ifid_flush_next & ~Reset;
    assign idex_flush = idex_flush_next & ~Reset;

    assign hz_state  = hz_state_reg;
    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: per-cycle expected controls are
// queued as each ID instruction is driven and compared when the DUT responds.
module tb_hazard_ctrl;

    localparam int CNT_W = 16;
    localparam int RA_W  = 5;

    localparam logic [1:0] S_RUN = 2'b00, S_LU = 2'b01, S_JR = 2'b10, S_FL = 2'b11;
    localparam logic [1:0] F_REG = 2'b00, F_MEM = 2'b10, F_WB = 2'b01;
    // {pc_stall, ifid_stall, ifid_flush, idex_flush}
    localparam logic [3:0] C_NONE = 4'b0000, C_STALL = 4'b1101,
                           C_BR = 4'b0011, C_JMP = 4'b0010;

    localparam logic [4:0] R0 = 5'd0, T0 = 5'd8, T1 = 5'd9, T2 = 5'd10, T3 = 5'd11,
                           T4 = 5'd12, T5 = 5'd13, T6 = 5'd14, S0 = 5'd16, RA = 5'd31;

    logic             slow_clk, Reset;
    logic             id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread;
    logic             id_jump, id_jr, ex_branch_taken;
    logic [RA_W-1:0]  id_rs, id_rt, id_rw;
    logic             pc_stall, ifid_stall, ifid_flush, idex_flush;
    logic [1:0]       fwd_a, fwd_b, hz_state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_ctrl #(.CNT_W(CNT_W), .RA_W(RA_W)) dut (
        .slow_clk        (slow_clk),
        .Reset           (Reset),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_regwrite     (id_regwrite),
        .id_rw           (id_rw),
        .id_memread      (id_memread),
        .id_jump         (id_jump),
        .id_jr           (id_jr),
        .ex_branch_taken (ex_branch_taken),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .hz_state        (hz_state),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    initial slow_clk = 1'b0;
    always #5 slow_clk = ~slow_clk;

    typedef struct {
        string      tag;
        logic [3:0] ctl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [1:0] hz;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt, input logic rwe,
                          input logic [4:0] rw, input logic mr, input logic j,
                          input logic jr, input logic br);
        id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_regwrite = rwe; id_rw = rw; id_memread = mr; id_jump = j; id_jr = jr;
        ex_branch_taken = br;
    endtask

    task automatic set_nop();
        set_id(1'b0, R0, R0, 1'b0, 1'b0, 1'b0, R0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // One pipeline cycle: queue expectation, compare controls mid-cycle,
    // then compare the registered action and counters after the edge.
    task automatic step(input string tag, input logic [3:0] ctl, input logic [1:0] fa,
                        input logic [1:0] fb, input logic [1:0] hz);
        exp_t e;
        e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb; e.hz = hz;
        sb_q.push_back(e);
        @(negedge slow_clk);
        e = sb_q.pop_front();
        check({e.tag, ".ctl"}, 32'({pc_stall, ifid_stall, ifid_flush, idex_flush}), 32'(e.ctl));
        check({e.tag, ".fwd_a"}, 32'(fwd_a), 32'(e.fa));
        check({e.tag, ".fwd_b"}, 32'(fwd_b), 32'(e.fb));
        @(posedge slow_clk);
        #1;
        if (e.hz == S_LU || e.hz == S_JR) exp_stall++;
        if (e.hz == S_FL) exp_flush++;
        check({e.tag, ".hz"}, 32'(hz_state), 32'(e.hz));
        check({e.tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        check({e.tag, ".flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
        $display("cycle %s ctl=%b fwd=%b/%b hz=%b cnt=%0d/%0d", e.tag,
                 {pc_stall, ifid_stall, ifid_flush, idex_flush}, fwd_a, fwd_b,
                 hz_state, stall_cnt, flush_cnt);
    endtask

    task automatic drain();
        set_nop();
        repeat (3) step("drain", C_NONE, F_REG, F_REG, S_RUN);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        set_nop();
        repeat (2) @(posedge slow_clk);
        #1;
        check("reset.ctl", 32'({pc_stall, ifid_stall, ifid_flush, idex_flush}), 32'(C_NONE));
        check("reset.hz", 32'(hz_state), 32'(S_RUN));
        check("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        check("reset.flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge slow_clk);
        Reset = 1'b0;
        @(posedge slow_clk);
        #1;

        // lw $t0 ; add $t1,$t0,$t2
        set_id(1, S0, T0, 1, 0, 1, T0, 1, 0, 0, 0);
        step("lu.lw", C_NONE, F_REG, F_REG, S_RUN);
        set_id(1, T0, T2, 1, 1, 1, T1, 0, 0, 0, 0);
        step("lu.add", C_STALL, F_REG, F_REG, S_LU);
`ifdef HAZARD_FWD_EN
        step("lu.add2", C_NONE, F_REG, F_REG, S_RUN);
        set_nop();
        step("lu.ex", C_NONE, F_WB, F_REG, S_RUN);
`else
        step("lu.add2", C_STALL, F_REG, F_REG, S_LU);
        step("lu.add3", C_NONE, F_REG, F_REG, S_RUN);
        set_nop();
        step("lu.ex", C_NONE, F_REG, F_REG, S_RUN);
`endif
        drain();

        // add $t0 ; sub $t3,$t1,$t0
        set_id(1, T1, T2, 1, 1, 1, T0, 0, 0, 0, 0);
        step("mem.add", C_NONE, F_REG, F_REG, S_RUN);
        set_id(1, T1, T0, 1, 1, 1, T3, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        step("mem.sub", C_NONE, F_REG, F_REG, S_RUN);
        set_nop();
        step("mem.ex", C_NONE, F_REG, F_MEM, S_RUN);
`else
        step("mem.sub", C_STALL, F_REG, F_REG, S_LU);
        step("mem.sub2", C_STALL, F_REG, F_REG, S_LU);
        step("mem.sub3", C_NONE, F_REG, F_REG, S_RUN);
        set_nop();
        step("mem.ex", C_NONE, F_REG, F_REG, S_RUN);
`endif
        drain();

        // add $t0 ; or $t4,$t5,$t6 ; sub $t3,$t1,$t0
        set_id(1, T1, T2, 1, 1, 1, T0, 0, 0, 0, 0);
        step("wb.add", C_NONE, F_REG, F_REG, S_RUN);
        set_id(1, T5, T6, 1, 1, 1, T4, 0, 0, 0, 0);
        step("wb.or", C_NONE, F_REG, F_REG, S_RUN);
        set_id(1, T1, T0, 1, 1, 1, T3, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        step("wb.sub", C_NONE, F_REG, F_REG, S_RUN);
        set_nop();
        step("wb.ex", C_NONE, F_REG, F_WB, S_RUN);
`else
        step("wb.sub", C_STALL, F_REG, F_REG, S_LU);
        step("wb.sub2", C_NONE, F_REG, F_REG, S_RUN);
        set_nop();
        step("wb.ex", C_NONE, F_REG, F_REG, S_RUN);
`endif
        drain();

        // addi $ra ; jr $ra back to back
        set_id(1, R0, R0, 1, 0, 1, RA, 0, 0, 0, 0);
        step("jr.addi", C_NONE, F_REG, F_REG, S_RUN);
        set_id(1, RA, R0, 0, 0, 0, R0, 0, 0, 1, 0);
        step("jr.stall1", C_STALL, F_REG, F_REG, S_JR);
        step("jr.stall2", C_STALL, F_REG, F_REG, S_JR);
        step("jr.go", C_JMP, F_REG, F_REG, S_FL);
        drain();

        // plain jump
        set_id(1, R0, R0, 0, 0, 0, R0, 0, 1, 0, 0);
        step("j", C_JMP, F_REG, F_REG, S_FL);
        drain();

        // taken branch beats a load-use condition
        set_id(1, S0, T0, 1, 0, 1, T0, 1, 0, 0, 0);
        step("br.lw", C_NONE, F_REG, F_REG, S_RUN);
        set_id(1, T0, T2, 1, 1, 1, T1, 0, 0, 0, 1);
        step("br.taken", C_BR, F_REG, F_REG, S_FL);
        set_nop();
        step("br.after", C_NONE, F_REG, F_REG, S_RUN);
        drain();

        // writes to $zero never create hazards
        set_id(1, S0, R0, 1, 0, 1, R0, 1, 0, 0, 0);
        step("zero.lw", C_NONE, F_REG, F_REG, S_RUN);
        set_id(1, R0, R0, 1, 1, 1, T1, 0, 0, 0, 0);
        step("zero.rd1", C_NONE, F_REG, F_REG, S_RUN);
        step("zero.rd2", C_NONE, F_REG, F_REG, S_RUN);
        set_nop();
        step("zero.ex", C_NONE, F_REG, F_REG, S_RUN);
        step("zero.ex2", C_NONE, F_REG, F_REG, S_RUN);
        drain();

        // reset in the middle of a JR stall
        set_id(1, R0, R0, 1, 0, 1, RA, 0, 0, 0, 0);
        step("rst.addi", C_NONE, F_REG, F_REG, S_RUN);
        set_id(1, RA, R0, 0, 0, 0, R0, 0, 0, 1, 0);
        step("rst.stall1", C_STALL, F_REG, F_REG, S_JR);
        #1;
        check("rst.pre", 32'({pc_stall, ifid_stall, ifid_flush, idex_flush}), 32'(C_STALL));
        Reset = 1'b1;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check("rst.ctl", 32'({pc_stall, ifid_stall, ifid_flush, idex_flush}), 32'(C_NONE));
        check("rst.fwd", 32'({fwd_a, fwd_b}), 32'd0);
        check("rst.hz", 32'(hz_state), 32'(S_RUN));
        check("rst.stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst.flush_cnt", 32'(flush_cnt), 32'd0);
        @(negedge slow_clk);
        Reset = 1'b0;
        set_nop();
        step("rst.post", C_NONE, F_REG, F_REG, S_RUN);

        // flush counter saturation: 2^CNT_W + 5 flush cycles
        @(negedge slow_clk);
        Reset = 1'b1;
        #1;
        @(negedge slow_clk);
        Reset = 1'b0;
        set_id(1, R0, R0, 0, 0, 0, R0, 0, 1, 0, 0);
        repeat ((1 << CNT_W) - 2) @(posedge slow_clk);
        #1;
        check("sat.pre", 32'(flush_cnt), 32'((1 << CNT_W) - 2));
        @(posedge slow_clk);
        #1;
        check("sat.reach", 32'(flush_cnt), 32'((1 << CNT_W) - 1));
        repeat (6) @(posedge slow_clk);
        #1;
        check("sat.hold", 32'(flush_cnt), 32'((1 << CNT_W) - 1));
        check("sat.hz", 32'(hz_state), 32'(S_FL));
        check("sat.stall_cnt", 32'(stall_cnt), 32'd0);
        $display("saturation flush_cnt=%0h after %0d flush cycles", flush_cnt, (1 << CNT_W) + 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
